// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Bridges the core's execute stage to the byte-lane data memory / GPIO block.
// Accepts one load or store at a time, decodes funct3 into a byte-enable
// mask, sequences the memory's one-cycle registered read latency, tolerates
// memory stalls up to STALL_MAX consecutive cycles, and returns sign- or
// zero-extended load data together with a one-cycle done pulse.
//
// Ports
//   I_clk, I_rst          clock, asynchronous active-high reset
//   I_req                 request strobe, only sampled while O_busy = 0
//   I_we                  1 = store, 0 = load
//   I_funct3              RISC-V funct3 of the load/store
//   I_addr                byte address (unaligned allowed, memory rotates)
//   I_wdata               store data, LSB-justified
//   O_busy                high while in ACCESS or CAPTURE
//   O_done                one-cycle completion pulse
//   O_err                 qualifies O_done: illegal funct3 or stall timeout
//   O_rdata               extended load result, held until next load
//   O_maddr/O_mdata       memory address / write data
//   O_mmask/O_mwe         memory byte mask / write enable
//   I_mdata               memory read data (valid the cycle after the read)
//   I_mstall              memory stall
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int STALL_MAX = 255,
  parameter int CNT_W     = 16
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_req,
  input  logic        I_we,
  input  logic [2:0]  I_funct3,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_wdata,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_err,
  output logic [31:0] O_rdata,
  output logic [31:0] O_maddr,
  output logic [31:0] O_mdata,
  output logic [3:0]  O_mmask,
  output logic        O_mwe,
  input  logic [31:0] I_mdata,
  input  logic        I_mstall
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(STALL_MAX);

  state_t            state_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [CNT_W-1:0]  stallCnt_q;
  logic [CNT_W-1:0]  stallCnt_d;

  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [31:0]       maddr_q;
  logic [31:0]       mdata_q;
  logic [3:0]        mmask_q;
  logic              mwe_q;

  logic              reqLegal;
  logic [3:0]        reqMask;
  logic [31:0]       loadExt;

  // Loads accept LB/LH/LW/LBU/LHU, stores only SB/SH/SW.
  always_comb begin
    reqLegal = 1'b0;
    case (I_funct3)
      3'b000, 3'b001, 3'b010: reqLegal = 1'b1;
      3'b100, 3'b101:         reqLegal = ~I_we;
      default:                reqLegal = 1'b0;
    endcase
  end

  // funct3[1:0] encodes the access size for both loads and stores.
  always_comb begin
    reqMask = 4'b1111;
    case (I_funct3[1:0])
      2'b00:   reqMask = 4'b0001;
      2'b01:   reqMask = 4'b0011;
      default: reqMask = 4'b1111;
    endcase
  end

  // Extension of the returned memory word, based on the latched funct3.
  always_comb begin
    loadExt = I_mdata;
    case (funct3_q)
      3'b000:  loadExt = {{24{I_mdata[7]}}, I_mdata[7:0]};
      3'b001:  loadExt = {{16{I_mdata[15]}}, I_mdata[15:0]};
      3'b100:  loadExt = {24'd0, I_mdata[7:0]};
      3'b101:  loadExt = {16'd0, I_mdata[15:0]};
      default: loadExt = I_mdata;
    endcase
  end

  assign stallCnt_d = stallCnt_q + CNT_W'(1);

  // Single FSM; every output is a register. done/err default low so that
  // they only ever pulse for one cycle.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'd0;
      stallCnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
      maddr_q    <= 32'd0;
      mdata_q    <= 32'd0;
      mmask_q    <= 4'd0;
      mwe_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (I_req) begin
            if (reqLegal) begin
              we_q       <= I_we;
              funct3_q   <= I_funct3;
              maddr_q    <= I_addr;
              mdata_q    <= I_wdata;
              mmask_q    <= reqMask;
              mwe_q      <= I_we;
              stallCnt_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= ACCESS;
            end else begin
              // Illegal op: report immediately, never touch memory.
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end

        ACCESS: begin
          if (I_mstall) begin
            stallCnt_q <= stallCnt_d;
            if (stallCnt_d == STALL_LIMIT) begin
              mwe_q   <= 1'b0;
              mmask_q <= 4'd0;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (we_q) begin
            mwe_q   <= 1'b0;
            mmask_q <= 4'd0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            // Memory sampled the read at this edge; data arrives next cycle.
            mmask_q <= 4'd0;
            state_q <= CAPTURE;
          end
        end

        CAPTURE: begin
          rdata_q <= loadExt;
          done_q  <= 1'b1;
          mmask_q <= 4'd0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          mwe_q   <= 1'b0;
          mmask_q <= 4'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign O_busy  = busy_q;
  assign O_done  = done_q;
  assign O_err   = err_q;
  assign O_rdata = rdata_q;
  assign O_maddr = maddr_q;
  assign O_mdata = mdata_q;
  assign O_mmask = mmask_q;
  assign O_mwe   = mwe_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. Each request pushes its expected
// outcome (latency, error flag, load value and the memory-side signals of the
// access cycle) onto a scoreboard queue; the entry is popped and compared
// when the DUT raises O_done.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int STALL_MAX_TB = 4;

  typedef struct {
    logic        legal;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        err;
    logic        loadOk;
    logic [31:0] loadVal;
    int          lat;
    int          stalls;
  } exp_t;

  logic        I_clk;
  logic        I_rst;
  logic        I_req;
  logic        I_we;
  logic [2:0]  I_funct3;
  logic [31:0] I_addr;
  logic [31:0] I_wdata;
  logic        O_busy;
  logic        O_done;
  logic        O_err;
  logic [31:0] O_rdata;
  logic [31:0] O_maddr;
  logic [31:0] O_mdata;
  logic [3:0]  O_mmask;
  logic        O_mwe;
  logic [31:0] I_mdata;
  logic        I_mstall;

  int          checks;
  int          errors;
  exp_t        sb[$];
  logic [31:0] modelRdata;

  load_store_unit #(
    .STALL_MAX (STALL_MAX_TB),
    .CNT_W     (16)
  ) dut (
    .I_clk    (I_clk),
    .I_rst    (I_rst),
    .I_req    (I_req),
    .I_we     (I_we),
    .I_funct3 (I_funct3),
    .I_addr   (I_addr),
    .I_wdata  (I_wdata),
    .O_busy   (O_busy),
    .O_done   (O_done),
    .O_err    (O_err),
    .O_rdata  (O_rdata),
    .O_maddr  (O_maddr),
    .O_mdata  (O_mdata),
    .O_mmask  (O_mmask),
    .O_mwe    (O_mwe),
    .I_mdata  (I_mdata),
    .I_mstall (I_mstall)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // Legal funct3 set for loads and stores.
  function automatic logic isLegal(input logic we, input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) return 1'b1;
    if (!we && (f3 == 3'b100 || f3 == 3'b101)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] maskOf(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 4'b0001;
    if (f3[1:0] == 2'b01) return 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] extendOf(input logic [2:0] f3, input logic [31:0] m);
    case (f3)
      3'b000:  return {{24{m[7]}}, m[7:0]};
      3'b001:  return {{16{m[15]}}, m[15:0]};
      3'b100:  return {24'h000000, m[7:0]};
      3'b101:  return {16'h0000, m[15:0]};
      default: return m;
    endcase
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Drives a request (just after a falling edge) and records its expectation.
  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] mdata, input int stalls);
    exp_t e;
    logic timeout;
    I_req    = 1'b1;
    I_we     = we;
    I_funct3 = f3;
    I_addr   = addr;
    I_wdata  = wdata;
    I_mdata  = mdata;
    e.legal   = isLegal(we, f3);
    e.we      = we;
    e.addr    = addr;
    e.data    = wdata;
    e.mask    = maskOf(f3);
    timeout   = e.legal && (stalls >= STALL_MAX_TB);
    e.err     = !e.legal || timeout;
    e.loadOk  = e.legal && !we && !timeout;
    e.loadVal = extendOf(f3, mdata);
    e.stalls  = stalls;
    if (!e.legal)     e.lat = 1;
    else if (timeout) e.lat = STALL_MAX_TB + 1;
    else              e.lat = (we ? 2 : 3) + stalls;
    sb.push_back(e);
  endtask

  // Waits (bounded) for O_done of the oldest request and compares. Returns
  // on the falling edge where O_done is seen, so the caller may issue a
  // back-to-back request in that very cycle.
  task automatic checkOutput(input string tag, input bit holdReq);
    exp_t e;
    bit   seen;
    int   doneAt;
    logic [31:0] expRdata;
    e      = sb[0];
    seen   = 1'b0;
    doneAt = 0;
    for (int k = 1; k <= e.lat + 2 && !seen; k++) begin
      @(negedge I_clk);
      if (k == 1 && !holdReq) I_req = 1'b0;
      I_mstall = (k <= e.stalls);
      if (k == 1) begin
        if (e.legal) begin
          checkVal({tag, "_busy"},  32'(O_busy),  32'd1);
          checkVal({tag, "_mwe"},   32'(O_mwe),   32'(e.we));
          checkVal({tag, "_mmask"}, 32'(O_mmask), 32'(e.mask));
          checkVal({tag, "_maddr"}, O_maddr, e.addr);
          checkVal({tag, "_mdata"}, O_mdata, e.data);
        end else begin
          checkVal({tag, "_ill_mmask"}, 32'(O_mmask), 32'd0);
          checkVal({tag, "_ill_mwe"},   32'(O_mwe),   32'd0);
        end
      end
      if (O_done === 1'b1) begin
        seen   = 1'b1;
        doneAt = k;
      end
    end
    I_mstall = 1'b0;
    checkVal({tag, "_done_seen"}, 32'(seen), 32'd1);
    checkVal({tag, "_latency"}, 32'(doneAt), 32'(e.lat));
    void'(sb.pop_front());
    expRdata = e.loadOk ? e.loadVal : modelRdata;
    modelRdata = expRdata;
    checkVal({tag, "_err"},   32'(O_err),   32'(e.err));
    checkVal({tag, "_rdata"}, O_rdata, expRdata);
    checkVal({tag, "_done_mwe"},   32'(O_mwe),   32'd0);
    checkVal({tag, "_done_mmask"}, 32'(O_mmask), 32'd0);
    checkVal({tag, "_done_busy"},  32'(O_busy),  32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_busy"},  32'(O_busy),  32'd0);
    checkVal({tag, "_done"},  32'(O_done),  32'd0);
    checkVal({tag, "_err"},   32'(O_err),   32'd0);
    checkVal({tag, "_rdata"}, O_rdata, 32'd0);
    checkVal({tag, "_maddr"}, O_maddr, 32'd0);
    checkVal({tag, "_mdata"}, O_mdata, 32'd0);
    checkVal({tag, "_mmask"}, 32'(O_mmask), 32'd0);
    checkVal({tag, "_mwe"},   32'(O_mwe),   32'd0);
  endtask

  initial begin
    bit anyDone;
    checks     = 0;
    errors     = 0;
    modelRdata = 32'd0;
    I_rst      = 1'b1;
    I_req      = 1'b0;
    I_we       = 1'b0;
    I_funct3   = 3'd0;
    I_addr     = 32'd0;
    I_wdata    = 32'd0;
    I_mdata    = 32'd0;
    I_mstall   = 1'b0;

    repeat (2) @(negedge I_clk);
    checkAllZero("reset");
    I_rst = 1'b0;
    @(negedge I_clk);

    $display("[TB] store / load round trip");
    applyStimulus(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0);
    checkOutput("sw_100", 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
    checkOutput("lw_100", 1'b0);

    $display("[TB] load extension");
    applyStimulus(1'b0, 3'b000, 32'h0000_0200, 32'h0, 32'h0000_0080, 0);
    checkOutput("lb", 1'b0);
    applyStimulus(1'b0, 3'b100, 32'h0000_0200, 32'h0, 32'h0000_0080, 0);
    checkOutput("lbu", 1'b0);
    applyStimulus(1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h0000_8001, 0);
    checkOutput("lh", 1'b0);
    applyStimulus(1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h0000_8001, 0);
    checkOutput("lhu", 1'b0);

    $display("[TB] unaligned half store and byte store to GPIO");
    applyStimulus(1'b1, 3'b001, 32'h0000_0103, 32'h1234_ABCD, 32'h0, 0);
    checkOutput("sh_103", 1'b0);
    applyStimulus(1'b1, 3'b000, 32'h0000_0000, 32'h0000_00A5, 32'h0, 0);
    checkOutput("sb_gpio", 1'b0);

    $display("[TB] stalls and timeout");
    applyStimulus(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 3);
    checkOutput("lw_stall3", 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h0000_0304, 32'h0, 32'h5555_AAAA, 100);
    checkOutput("lw_timeout", 1'b0);
    applyStimulus(1'b1, 3'b010, 32'h0000_0308, 32'h0BAD_F00D, 32'h0, 100);
    checkOutput("sw_timeout", 1'b0);

    $display("[TB] illegal funct3");
    applyStimulus(1'b0, 3'b011, 32'h0000_0400, 32'h0, 32'h1234_5678, 0);
    checkOutput("ld_f3_011", 1'b0);
    applyStimulus(1'b1, 3'b100, 32'h0000_0400, 32'h1111_2222, 32'h0, 0);
    checkOutput("st_f3_100", 1'b0);

    $display("[TB] held request and back-to-back accept");
    applyStimulus(1'b0, 3'b001, 32'h0000_0500, 32'h0, 32'h0000_7FFE, 0);
    checkOutput("lh_held", 1'b1);
    applyStimulus(1'b1, 3'b010, 32'h0000_0504, 32'h8765_4321, 32'h0, 0);
    checkOutput("sw_b2b", 1'b0);
    @(negedge I_clk);
    checkVal("b2b_idle_done", 32'(O_done), 32'd0);
    checkVal("b2b_idle_busy", 32'(O_busy), 32'd0);

    $display("[TB] reset during capture");
    applyStimulus(1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'h1111_1111, 0);
    @(negedge I_clk);
    I_req = 1'b0;
    @(negedge I_clk);
    checkVal("rst_mid_busy_before", 32'(O_busy), 32'd1);
    I_rst = 1'b1;
    #1;
    checkAllZero("rst_mid");
    void'(sb.pop_front());
    modelRdata = 32'd0;
    @(negedge I_clk);
    I_rst   = 1'b0;
    anyDone = 1'b0;
    repeat (3) begin
      @(negedge I_clk);
      if (O_done === 1'b1) anyDone = 1'b1;
    end
    checkVal("rst_mid_no_done", 32'(anyDone), 32'd0);
    applyStimulus(1'b0, 3'b100, 32'h0000_0700, 32'h0, 32'h0000_00F0, 0);
    checkOutput("lbu_after_rst", 1'b0);
    I_req = 1'b0;
    repeat (2) @(negedge I_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the core's execute stage and the byte-lane data memory/GPIO block, driving its I_addr/I_data/I_mask/I_we port and consuming its registered O_data and O_stall. It accepts one RISC-V load/store request at a time and decodes funct3 into byte-enable masks. It sequences the memory's 1-cycle registered read latency and honours memory stalls, with a timeout. It returns sign- or zero-extended load data to the core with a done pulse.

Parameters:
STALL_MAX, 255, maximum consecutive stalled ACCESS cycles before the request is aborted with an error; must be 1..65535.
CNT_W, 16, width of the stall counter; must satisfy STALL_MAX < 2^CNT_W.

Ports:
I_clk  in  1  clock, all state updates on its rising edge
I_rst  in  1  reset, asynchronous, active-high
I_req  in  1  core request strobe; sampled only when O_busy=0
I_we  in  1  1=store, 0=load
I_funct3  in  3  RISC-V funct3 of the load/store
I_addr  in  32  byte address; unaligned addresses allowed, memory rotates lanes
I_wdata  in  32  store data, LSB-justified
O_busy  out  1  high whenever state is not IDLE
O_done  out  1  one-cycle pulse when the request completes
O_err  out  1  qualifies O_done: illegal funct3 or stall timeout
O_rdata  out  32  extended load result; valid with O_done, held until the next load completes
O_maddr  out  32  to memory I_addr
O_mdata  out  32  to memory I_data
O_mmask  out  4  to memory I_mask
O_mwe  out  1  to memory I_we
I_mdata  in  32  from memory O_data; valid the cycle after the memory samples a read
I_mstall  in  1  from memory O_stall

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, stall counter 0. A request in flight is dropped with no O_done.
- States: IDLE, ACCESS, CAPTURE. All outputs are registered. O_busy is asserted in ACCESS and CAPTURE.
- IDLE:
  - With I_req=1, latch the operation.
  - Legal op: load O_maddr=I_addr, O_mdata=I_wdata unshifted, O_mmask from funct3, O_mwe=I_we; go to ACCESS.
  - Illegal op: next cycle O_done=O_err=1, no memory access, stay in IDLE.
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal funct3 for stores: 000 SB, 001 SH, 010 SW. Every other combination is illegal.
- Masks: byte ops 0001, half ops 0011, word ops 1111.
- ACCESS: memory samples the outputs at the closing edge.
  - If I_mstall=1 at that edge: remain in ACCESS with outputs held and increment the stall counter.
  - If the counter reaches STALL_MAX: drop O_mwe/O_mmask to 0, pulse O_done=O_err=1, go to IDLE.
  - Store, no stall: O_mwe<=0, O_mmask<=0, O_done<=1, go to IDLE.
  - Load, no stall: go to CAPTURE.
- CAPTURE: at the closing edge, O_rdata<=extend(I_mdata), O_done<=1, O_mmask<=0, go to IDLE.
  - LB: sign-extend [7:0]. LBU: zero-extend [7:0]. LH: sign-extend [15:0]. LHU: zero-extend [15:0]. LW: pass all 32 bits.
- Latency from the accept edge, with no stall: store O_done is high 2 cycles later; load O_done and O_rdata are valid 3 cycles later.
- O_done is a single cycle, seen in IDLE. A new I_req in that same cycle is accepted (back-to-back).
- I_req while O_busy=1 is ignored, not queued.
- O_maddr and O_mdata hold their last value in IDLE. O_mwe and O_mmask are 0 outside ACCESS.
- O_err is 0 whenever O_done is 0. The stall counter clears on entry to ACCESS.
- Store to address 0 is an ordinary store; the memory block routes it to GPIO.

Test Plan:
- Reset mid-load: assert I_rst during CAPTURE -> all outputs 0 immediately, no O_done, next I_req accepted normally.
- SW addr=0x100 data=0xDEADBEEF -> one cycle with O_mwe=1, mask=1111, O_maddr=0x100. Then O_done 2 cycles after accept, O_err=0. A subsequent LW 0x100 with I_mdata=0xDEADBEEF -> O_rdata=0xDEADBEEF.
- LB with I_mdata=0x00000080 -> O_rdata=0xFFFFFF80. LBU -> 0x00000080. LH with 0x00008001 -> 0xFFFF8001. LHU -> 0x00008001.
- SH addr=0x103 data=0x1234ABCD -> mask=0011, O_mdata=0x1234ABCD unshifted, addr 0x103 passed through.
- Load with I_mstall=1 for 3 ACCESS edges -> O_done 3 cycles late with correct data. With I_mstall stuck high and STALL_MAX=4 -> O_done=O_err=1 after 4 stalled edges, O_mwe=0.
- I_funct3=011 load -> O_done=O_err=1 next cycle, O_mmask/O_mwe stay 0. I_req held through the O_done cycle of a legal load -> second request accepted immediately.
